// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - Shared types and immediate limits for the instruction memory loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_RANGE    = 3'd1,
    ERR_ALIGN    = 3'd2,
    ERR_FMT      = 3'd3,
    ERR_OVERFLOW = 3'd4,
    ERR_READBACK = 3'd5
  } err_t;

  // Signed byte-offset limits for the I/S, B and J immediates.
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM13_MAX = 32'sd4094;
  localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM21_MAX = 32'sd1048574;

endpackage

// File: rtl/instr_field_encoder.sv
// rtl/instr_field_encoder.sv - Combinational RV32I field packer with immediate legality checks.
module instr_field_encoder
  import instr_loader_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [2:0]  err_code
);

  logic signed [31:0] simm;
  assign simm = imm;

  // Range is checked after alignment so that it wins when both apply.
  always_comb begin
    word     = '0;
    err_code = ERR_NONE;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, op};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, op};
        if (simm < IMM12_MIN || simm > IMM12_MAX) err_code = ERR_RANGE;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        if (simm < IMM12_MIN || simm > IMM12_MAX) err_code = ERR_RANGE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        if (imm[0]) err_code = ERR_ALIGN;
        if (simm < IMM13_MIN || simm > IMM13_MAX) err_code = ERR_RANGE;
      end
      FMT_U: begin
        word = {imm[31:12], rd, op};
        if (imm[11:0] != 12'd0) err_code = ERR_ALIGN;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (imm[0]) err_code = ERR_ALIGN;
        if (simm < IMM21_MIN || simm > IMM21_MAX) err_code = ERR_RANGE;
      end
      default: err_code = ERR_FMT;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - Packs field-level requests into RV32I words and writes them to instruction memory.
// Optional write readback check enabled by INSTR_LOADER_READBACK_EN.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [2:0]        req_fmt,
  input  logic [6:0]        req_op,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
`ifdef INSTR_LOADER_READBACK_EN
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef INSTR_LOADER_READBACK_EN
  localparam logic [2:0] S_VERIFY = 3'd4;
`endif

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic              full;
  logic              last_q;
  logic [31:0]       enc_word;
  logic [2:0]        enc_err;
  logic [2:0]        acc_err;
  logic [2:0]        new_err;
  logic              handshake;
  logic              step_addr;
`ifdef INSTR_LOADER_READBACK_EN
  logic              verify_pend;
`endif

  instr_field_encoder u_enc (
    .fmt      (req_fmt),
    .op       (req_op),
    .funct3   (req_funct3),
    .funct7   (req_funct7),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .imm      (req_imm),
    .word     (enc_word),
    .err_code (enc_err)
  );

  assign req_ready = (state == S_ACCEPT);
  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = addr;
  assign done      = (state == S_DONE);
  assign handshake = req_valid & req_ready;
  // Once the top word has been written, every later request overflows.
  assign acc_err   = full ? ERR_OVERFLOW : enc_err;

`ifdef INSTR_LOADER_READBACK_EN
  assign mem_re    = (state == S_VERIFY);
  assign busy      = (state == S_ACCEPT) || (state == S_WRITE) || (state == S_VERIFY);
  assign step_addr = (state == S_VERIFY);
`else
  assign busy      = (state == S_ACCEPT) || (state == S_WRITE);
  assign step_addr = (state == S_WRITE) && mem_ack;
`endif

  always_comb begin
    new_err = ERR_NONE;
    if (handshake) new_err = acc_err;
`ifdef INSTR_LOADER_READBACK_EN
    // Readback belongs to the earlier word, so it takes precedence.
    if (verify_pend && (mem_rdata != mem_wdata)) new_err = ERR_READBACK;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      addr          <= '0;
      full          <= 1'b0;
      last_q        <= 1'b0;
      mem_wdata     <= '0;
      err           <= 1'b0;
      err_code      <= '0;
      words_written <= '0;
`ifdef INSTR_LOADER_READBACK_EN
      verify_pend   <= 1'b0;
`endif
    end else begin
`ifdef INSTR_LOADER_READBACK_EN
      verify_pend <= (state == S_VERIFY);
`endif
      if (new_err != ERR_NONE) begin
        err <= 1'b1;
        if (err_code == ERR_NONE) err_code <= new_err;
      end
      if (step_addr) begin
        if (addr == {ADDR_W{1'b1}}) full <= 1'b1;
        else                        addr <= addr + ADDR_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_ACCEPT;
            addr          <= base_addr;
            full          <= 1'b0;
            err           <= 1'b0;
            err_code      <= '0;
            words_written <= '0;
          end
        end
        S_ACCEPT: begin
          if (handshake) begin
            last_q    <= req_last;
            mem_wdata <= enc_word;
            if (acc_err == ERR_NONE) state <= S_WRITE;
            else if (req_last)       state <= S_DONE;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            words_written <= words_written + (ADDR_W+1)'(1);
`ifdef INSTR_LOADER_READBACK_EN
            state <= S_VERIFY;
`else
            state <= last_q ? S_DONE : S_ACCEPT;
`endif
          end
        end
`ifdef INSTR_LOADER_READBACK_EN
        S_VERIFY: state <= last_q ? S_DONE : S_ACCEPT;
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - Scoreboard bench for instr_mem_loader (default and ADDR_W=2 instances).
module tb_instr_mem_loader;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

  logic        clk, reset;
  logic        start, req_valid, req_ready, req_last;
  logic [7:0]  base_addr;
  logic [2:0]  req_fmt, req_funct3;
  logic [6:0]  req_op, req_funct7;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        mem_we, mem_ack, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  err_code;
  logic [8:0]  words_written;

  logic        s_start, s_req_valid, s_req_ready, s_mem_we, s_mem_ack, s_busy, s_done, s_err;
  logic [1:0]  s_base_addr, s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_err_code;
  logic [2:0]  s_words_written;

  int errors = 0;
  int checks = 0;
  logic [39:0] sb[$];
  logic [39:0] exp_entry;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [7:0]  held_addr;
  logic [31:0] held_data;
  int s_writes = 0;
  logic [1:0]  s_last_addr;
  logic [31:0] s_last_data;

  instr_mem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_fmt(req_fmt), .req_op(req_op), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .words_written(words_written)
  );

  instr_mem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .base_addr(s_base_addr),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_last(req_last),
    .req_fmt(req_fmt), .req_op(req_op), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_ack(s_mem_ack),
    .busy(s_busy), .done(s_done), .err(s_err), .err_code(s_err_code), .words_written(s_words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Memory model for the main instance: ack after ack_delay wait cycles, score each accepted write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wait_cnt == 0) begin
        held_addr = mem_addr;
        held_data = mem_wdata;
      end else begin
        check("we_addr_stable", mem_addr, held_addr);
        check("we_data_stable", mem_wdata, held_data);
      end
      check("ready_in_write", req_ready, 0);
      if (wait_cnt >= ack_delay) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_entry = sb.pop_front();
          check("mem_addr", mem_addr, exp_entry[39:32]);
          check("mem_wdata", mem_wdata, exp_entry[31:0]);
        end
        mem_ack  = 1'b1;
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    s_mem_ack = s_mem_we;
    if (s_mem_we) begin
      s_writes++;
      s_last_addr = s_mem_addr;
      s_last_data = s_mem_wdata;
    end
  end

  task automatic send(input bit sel, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input bit last, input bit ok, input logic [31:0] w, input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    req_fmt = fmt; req_op = op; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_last = last;
    if (sel) s_req_valid = 1'b1;
    else     req_valid = 1'b1;
    if (ok && !sel) sb.push_back({a, w});
    while (!(sel ? s_req_ready : req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", sel ? s_req_ready : req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    s_req_valid = 1'b0;
  endtask

  task automatic start_session(input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_session(input logic [8:0] w_words, input logic w_err, input logic [2:0] w_code);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done", done, 1);
    check("words_written", words_written, w_words);
    check("err", err, w_err);
    check("err_code", err_code, w_code);
    check("sb_drained", sb.size(), 0);
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; req_valid = 1'b0; req_last = 1'b0;
    req_fmt = '0; req_op = '0; req_funct3 = '0; req_funct7 = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; mem_ack = 1'b0;
    s_start = 1'b0; s_base_addr = '0; s_req_valid = 1'b0; s_mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_words", words_written, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single R-type add at 0x10.
    start_session(8'h10);
    send(0, F_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 1, 32'h002081B3, 8'h10);
    finish_session(9'd1, 1'b0, 3'd0);

    // Consecutive addresses; a stray start mid-session must be ignored.
    start_session(8'h40);
    send(0, F_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 1, 32'h00208463, 8'h40);
    @(negedge clk); start = 1'b1; base_addr = 8'h80;
    @(negedge clk); start = 1'b0;
    send(0, F_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd4, 0, 1, 32'hFFDFF0EF, 8'h41);
    send(0, F_S, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 1, 32'h0020A423, 8'h42);
    finish_session(9'd3, 1'b0, 3'd0);

    // Alignment then range error: first code kept, address not advanced.
    start_session(8'h50);
    send(0, F_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7, 0, 0, 32'd0, 8'h00);
    send(0, F_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 0, 32'd0, 8'h00);
    send(0, F_I, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1, 1, 32'hFFF00293, 8'h50);
    finish_session(9'd1, 1'b1, 3'd2);

    // Immediate boundaries with slow memory acks.
    ack_delay = 3;
    start_session(8'h60);
    send(0, F_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 0, 1, 32'h7FF00093, 8'h60);
    send(0, F_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4097, 0, 0, 32'd0, 8'h00);
    send(0, F_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2048, 0, 1, 32'h80000093, 8'h61);
    send(0, F_U, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345123, 0, 0, 32'd0, 8'h00);
    send(0, F_J, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h000FFFFE, 0, 1, 32'h7FFFF06F, 8'h62);
    send(0, F_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094, 0, 1, 32'h7E000FE3, 8'h63);
    send(0, F_J, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFEFFFFE, 0, 0, 32'd0, 8'h00);
    send(0, F_U, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 1, 1, 32'h123450B7, 8'h64);
    finish_session(9'd5, 1'b1, 3'd1);
    ack_delay = 0;

    // Bad format code as the only request.
    start_session(8'h70);
    send(0, 3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1, 0, 32'd0, 8'h00);
    finish_session(9'd0, 1'b1, 3'd3);

    // Overflow on the 4-word instance.
    @(negedge clk); s_start = 1'b1; s_base_addr = 2'd3;
    @(negedge clk); s_start = 1'b0;
    send(1, F_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 1, 32'd0, 8'h00);
    send(1, F_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 1, 32'd0, 8'h00);
    begin
      int n = 0;
      while (!s_done && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("s_done", s_done, 1);
    check("s_err", s_err, 1);
    check("s_err_code", s_err_code, 4);
    check("s_words", s_words_written, 1);
    check("s_writes", s_writes, 1);
    check("s_last_addr", s_last_addr, 3);
    check("s_last_data", s_last_data, 32'h002081B3);
    check("s_addr_no_wrap", s_mem_addr, 3);

    // Reset while a write is outstanding.
    ack_delay = 100;
    start_session(8'h20);
    send(0, F_R, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 1, 32'h002081B3, 8'h20);
    @(negedge clk);
    check("we_before_reset", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    check("reset_mem_we", mem_we, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", req_ready, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    start_session(8'h20);
    send(0, F_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 1, 1, 32'h7FF00093, 8'h20);
    finish_session(9'd1, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side counterpart to the core's instruction decode. It accepts field-level instruction requests (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake.
- It packs each request into a 32-bit RV32I word and writes the word into instruction memory at consecutive word addresses.
- Used by boot/test infrastructure to load programs that the single-cycle core then fetches and decodes.

Parameters:
- ADDR_W, 8, word-address width; capacity 2**ADDR_W words.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load session at base_addr
- base_addr  in  ADDR_W  first word address of the session
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_last  in  1  request is the final one of the session
- req_fmt  in  3  instruction format code (package enum)
- req_op  in  7  opcode
- req_funct3  in  3  funct3
- req_funct7  in  7  funct7 (R format only)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  signed byte-offset or upper immediate
- mem_we  out  1  write strobe, held until mem_ack
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepted the write
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at end of session
- err  out  1  sticky error flag
- err_code  out  3  first error of the session
- words_written  out  ADDR_W+1  successful writes this session

Behaviour:
- Reset values: all outputs 0; state IDLE.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - start moves to ACCEPT.
  - Loads address from base_addr.
  - Clears err, err_code and words_written.
  - start is ignored in any other state.
- ACCEPT:
  - req_ready=1.
  - On a handshake, the request is encoded combinationally and registered into mem_wdata; last is captured.
  - A legal request goes to WRITE.
  - An illegal request is dropped: no write, error recorded; go to DONE if last, else stay in ACCEPT.
- WRITE:
  - mem_we=1 with mem_addr/mem_wdata stable until mem_ack.
  - On ack: address+1, words_written+1; go to DONE if last, else ACCEPT.
  - req_ready=0 throughout.
- DONE: done=1 for one cycle, then IDLE. busy=1 in ACCEPT and WRITE.
- Throughput: at most one word per 2 cycles (ack in the first WRITE cycle).
- Encoding, by format:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Error codes:
  - 1 = range: I/S not in [-2048,2047]; B not in [-4096,4094]; J not in [-2^20, 2^20-2].
  - 2 = alignment: B/J imm[0]=1; U imm[11:0]≠0.
  - 3 = bad format code (6, 7).
  - 4 = overflow: request arrives after the write at address 2**ADDR_W-1 completed. The address does not wrap; all further requests are dropped with code 4.
  - 5 = readback mismatch (optional feature only).
- Error reporting:
  - err_code keeps the first error of the session.
  - err stays high until the next start.
  - Simultaneous range and alignment errors report code 1.
- Reset mid-WRITE: mem_we drops immediately (async); the session is abandoned.

Optional Feature:
- Macro: INSTR_LOADER_READBACK_EN.
- Defined:
  - Adds ports mem_re (out, 1) and mem_rdata (in, 32), plus state VERIFY after WRITE.
  - VERIFY asserts mem_re at the same address (pre-increment) for one cycle and compares mem_rdata on the next cycle.
  - A mismatch sets code 5; the session continues.
  - Latency becomes 3 cycles per word minimum.
- Undefined: ports and state are absent; WRITE goes directly to ACCEPT or DONE.

Decomposition:
- Package instr_loader_pkg:
  - fmt_t enum (FMT_R=0, I=1, S=2, B=3, U=4, J=5).
  - err_t codes (0–5).
  - Immediate range constants.
- Sub-module instr_field_encoder (purely combinational): fmt, fields and imm in; word and error code out. The FSM instantiates it once.

Test Plan:
- start, base_addr=0x10; R add (op 0x33, rd3, rs1 1, rs2 2, f3 0, f7 0) with last=1; ack next cycle -> mem_addr=0x10, mem_wdata=0x002081B3; then done pulse, words_written=1, err=0.
- B beq rs1=1, rs2=2, imm=8 -> 0x00208463; J jal rd=1, imm=-4 -> 0xFFDFF0EF; written at consecutive addresses.
- B imm=7 then I imm=2048 -> neither written; err=1, err_code=2 (first error); words_written unchanged.
- mem_ack delayed 3 cycles -> mem_we, mem_addr, mem_wdata stable for 4 cycles; req_ready=0 throughout.
- ADDR_W=2, base_addr=3, two requests -> first written at 3, second dropped with err_code=4; done after last.
- Reset low during WRITE -> mem_we=0 the same cycle, busy=0, FSM in IDLE; a later start works normally.
